// File: rtl/dmem_arbiter_if.sv
// Bundle of core-side and memory-side handshake signals around the data-memory arbiter.
// Pure wiring: no logic, no latency.
// Valid/yumi in both directions; a side holds valid until it sees yumi.
interface dmem_arbiter_if #(
  parameter int num_req_p = 4
);
  // core-side request/response
  logic [num_req_p-1:0]    req_valid_i;
  logic [num_req_p-1:0]    req_wen_i;
  logic [num_req_p-1:0]    req_byte_i;
  logic [32*num_req_p-1:0] req_addr_i;
  logic [32*num_req_p-1:0] req_wdata_i;
  logic [num_req_p-1:0]    req_yumi_o;
  logic [num_req_p-1:0]    resp_valid_o;
  logic [31:0]             resp_data_o;
  logic [num_req_p-1:0]    resp_yumi_i;
  // memory-side request/response
  logic                    mem_valid_o;
  logic                    mem_wen_o;
  logic                    mem_byte_o;
  logic [31:0]             mem_addr_o;
  logic [31:0]             mem_wdata_o;
  logic                    mem_yumi_i;
  logic                    mem_valid_i;
  logic [31:0]             mem_rdata_i;
  logic                    mem_yumi_o;

  // arbiter view
  modport slave (
    input  req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i, resp_yumi_i,
    input  mem_yumi_i, mem_valid_i, mem_rdata_i,
    output req_yumi_o, resp_valid_o, resp_data_o,
    output mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o, mem_yumi_o
  );

  // core array + memory view
  modport master (
    output req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i, resp_yumi_i,
    output mem_yumi_i, mem_valid_i, mem_rdata_i,
    input  req_yumi_o, resp_valid_o, resp_data_o,
    input  mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o, mem_yumi_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among num_req_p cores, one transaction in flight.
// Latency: request in IDLE at t drives mem_valid_o at t+1; minimum transaction 3 cycles.
// Backpressure: yumi/valid paths are combinational pass-throughs; core and memory may stall indefinitely.
module dmem_arbiter #(
  parameter int num_req_p = 4,
  parameter int timeout_p = 255
) (
  input  logic                         clk,
  input  logic                         n_reset,
  dmem_arbiter_if.slave                bus,
  output logic [$clog2(num_req_p)-1:0] grant_o,
  output logic                         busy_o,
  output logic                         error_o
);
  localparam int gw = $clog2(num_req_p);
  localparam int cw = $clog2(timeout_p + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t         state_q, state_d;
  logic [gw-1:0]  grant_q, grant_d;
  logic [gw-1:0]  last_grant_q, last_grant_d;
  logic           wen_q, wen_d;
  logic           byte_q, byte_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [cw-1:0]  wait_cnt_q, wait_cnt_d;
  logic           error_q, error_d;

  logic           found;
  logic [gw-1:0]  sel;
  logic [gw-1:0]  cand;

  // Round-robin pick: first valid core searching upward from last_grant+1, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 1; i <= num_req_p; i++) begin
      cand = gw'((int'(last_grant_q) + i) % num_req_p);
      if (!found && bus.req_valid_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Next-state, request latching and handshake steering.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_grant_d     = last_grant_q;
    wen_d            = wen_q;
    byte_d           = byte_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    bus.req_yumi_o   = '0;
    bus.resp_valid_o = '0;
    bus.mem_valid_o  = 1'b0;
    bus.mem_yumi_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = sel;
          wen_d   = bus.req_wen_i[sel];
          byte_d  = bus.req_byte_i[sel];
          addr_d  = bus.req_addr_i[32*int'(sel) +: 32];
          wdata_d = bus.req_wdata_i[32*int'(sel) +: 32];
          state_d = REQ;
        end
      end
      REQ: begin
        bus.mem_valid_o         = 1'b1;
        bus.req_yumi_o[grant_q] = bus.mem_yumi_i;
        if (bus.mem_yumi_i) state_d = RESP;
      end
      RESP: begin
        bus.resp_valid_o[grant_q] = bus.mem_valid_i;
        bus.mem_yumi_o            = bus.mem_valid_i & bus.resp_yumi_i[grant_q];
        if (bus.mem_valid_i && bus.resp_yumi_i[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog: restart on grant, count while busy, saturate; error is sticky until reset.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == IDLE) begin
      if (found) wait_cnt_d = '0;
    end else if (wait_cnt_q != cw'(timeout_p)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    error_d = error_q | (wait_cnt_d == cw'(timeout_p) && state_q != IDLE);
  end

  // State and latch registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= gw'(num_req_p - 1);
      wen_q        <= 1'b0;
      byte_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wait_cnt_q   <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      byte_q       <= byte_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      error_q      <= error_d;
    end
  end

  // Memory request fields come straight from the latched request; read data is broadcast.
  assign bus.mem_wen_o   = wen_q;
  assign bus.mem_byte_o  = byte_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.resp_data_o = bus.mem_rdata_i;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q != IDLE);
  assign error_o         = error_q;
endmodule
